fir_tap_reader: RTL and testbench

//   Read side of the fir_shift_imem sample delay line. The writer shifts a new sample

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_mac.sv | 44 ++++
 rtl/fir_tap_reader.sv | 102 ++++++++++
 tb/tb_fir_tap_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants, FSM state encoding and the Q15 round/saturate helper
// used by every FIR stage that narrows an accumulator back to sample width.
package fir_pkg;

    localparam int TAPS   = 64;
    localparam int DW     = 16;
    localparam int AW     = $clog2(TAPS);
    localparam int ACC_W  = 2*DW + AW;
    localparam int QSHIFT = DW - 1;
    localparam int QW     = ACC_W - QSHIFT;

    localparam logic signed [DW-1:0]    SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]    SAT_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (DW-2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    // Round half up, arithmetic shift by QSHIFT, clamp to DW bits.
    function automatic logic signed [DW-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] biased;
        logic        [QW-1:0]    q;
        biased = acc + RND;
        q      = biased[ACC_W-1:QSHIFT];
        // In range only when every bit above the result sign matches it.
        if (q[QW-1:DW-1] == '0 || q[QW-1:DW-1] == '1)
            return q[DW-1:0];
        else if (q[QW-1])
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Product register, clear-on-first accumulator and the rounded/saturated
// output register for one filter sweep.
module fir_mac
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_vld,
    input  logic                 in_first,
    input  logic signed [DW-1:0] sample,
    input  logic signed [DW-1:0] coef,
    input  logic                 out_ld,
    output logic signed [DW-1:0] y
);

    logic signed [2*DW-1:0]  prod;
    logic                    prod_vld;
    logic                    prod_first;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;

    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (reset) begin
            prod       <= '0;
            prod_vld   <= 1'b0;
            prod_first <= 1'b0;
            acc        <= '0;
            y          <= '0;
        end else begin
            prod_vld   <= in_vld;
            prod_first <= in_first;
            if (in_vld)
                prod <= sample * coef;
            // First product of a sweep overwrites, so nothing leaks between samples.
            if (prod_vld)
                acc <= prod_first ? prod_ext : acc + prod_ext;
            if (out_ld)
                y <= sat_round(acc);
        end
    end

endmodule

// File: rtl/fir_tap_reader.sv
// Delay-line read sequencer: sweeps all taps after each sample strobe, tags the
// read stream through the memory latency and drives the MAC to one output per sweep.
module fir_tap_reader
    import fir_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_strb,
    output logic [AW-1:0]        read_addr,
    input  logic signed [DW-1:0] imem_rdata,
    output logic [AW-1:0]        coef_addr,
    input  logic signed [DW-1:0] coef_rdata,
    output logic signed [DW-1:0] y_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int DRAIN_CYC = RD_LAT + 2;
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $error("fir_tap_reader: RD_LAT must be 1 or 2");
    end

    fir_state_e       state;
    logic [DCW-1:0]   drain_cnt;
    logic [RD_LAT:0]  vld_pipe;
    logic [RD_LAT:0]  first_pipe;
    logic             out_ld;

    assign coef_addr = read_addr;
    assign out_ld    = (state == DRAIN) && (drain_cnt == DCW'(DRAIN_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            read_addr  <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            y_valid    <= 1'b0;
            overrun    <= 1'b0;
            vld_pipe   <= '0;
            first_pipe <= '0;
        end else begin
            overrun                 <= sample_strb & busy;
            y_valid                 <= 1'b0;
            // Tags ride alongside the read address until the data comes back.
            vld_pipe[RD_LAT:1]      <= vld_pipe[RD_LAT-1:0];
            first_pipe[RD_LAT:1]    <= first_pipe[RD_LAT-1:0];
            vld_pipe[0]             <= 1'b0;
            first_pipe[0]           <= 1'b0;

            case (state)
                IDLE, OUT: begin
                    read_addr <= '0;
                    if (sample_strb) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        vld_pipe[0]   <= 1'b1;
                        first_pipe[0] <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (read_addr == AW'(TAPS - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        read_addr   <= read_addr + AW'(1);
                        vld_pipe[0] <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ld) begin
                        state   <= OUT;
                        busy    <= 1'b0;
                        y_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fir_mac u_mac (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (vld_pipe[RD_LAT]),
        .in_first (first_pipe[RD_LAT]),
        .sample   (imem_rdata),
        .coef     (coef_rdata),
        .out_ld   (out_ld),
        .y        (y_out)
    );

endmodule

// File: tb/tb_fir_tap_reader.sv
// Directed bench: models the delay line and coefficient ROM (1-cycle reads)
// and checks sequencing, latency and Q15 arithmetic against hand-computed values.
module tb_fir_tap_reader;

    localparam int TAPS = 64;
    localparam int LAT  = 68;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_strb;
    logic [5:0]  read_addr;
    logic [15:0] imem_rdata;
    logic [5:0]  coef_addr;
    logic [15:0] coef_rdata;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] new_sample;
    logic        preload;
    logic [15:0] preload_val;
    logic [15:0] dline [TAPS];
    logic [15:0] cmem  [TAPS];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fir_tap_reader #(.RD_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_strb (sample_strb),
        .read_addr   (read_addr),
        .imem_rdata  (imem_rdata),
        .coef_addr   (coef_addr),
        .coef_rdata  (coef_rdata),
        .y_out       (y_out),
        .y_valid     (y_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < TAPS; i++) dline[i] <= preload_val;
        end else if (sample_strb) begin
            for (int i = TAPS-1; i > 0; i--) dline[i] <= dline[i-1];
            dline[0] <= new_sample;
        end
        imem_rdata <= dline[read_addr];
        coef_rdata <= cmem[coef_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_coefs(input logic [15:0] c0, input logic [15:0] rest);
        for (int i = 0; i < TAPS; i++) cmem[i] = (i == 0) ? c0 : rest;
    endtask

    task automatic do_preload(input logic [15:0] v);
        preload_val = v;
        preload     = 1'b1;
        @(negedge clk);
        preload     = 1'b0;
    endtask

    // Called at a negedge: that cycle is cycle 0 of the strobe. Returns at the
    // negedge of the y_valid cycle so a follow-up call strobes in that cycle.
    task automatic sweep(input logic [15:0] s, input int ovr_at, output int vc,
                         output logic [15:0] y, output int ovr_seen, output bit seq_ok);
        vc = -1; y = '0; ovr_seen = -1; seq_ok = 1'b1;
        new_sample  = s;
        sample_strb = 1'b1;
        for (int c = 1; c <= 150 && vc < 0; c++) begin
            @(negedge clk);
            sample_strb = (c == ovr_at);
            if (overrun && ovr_seen < 0) ovr_seen = c;
            if (c <= TAPS && (read_addr != 6'(c-1) || coef_addr != 6'(c-1))) seq_ok = 1'b0;
            if (c > TAPS && c <= LAT && read_addr != 6'(TAPS-1)) seq_ok = 1'b0;
            if (busy != (c < LAT)) seq_ok = 1'b0;
            if (y_valid) begin vc = c; y = y_out; end
        end
    endtask

    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
    endtask

    int          vc, ov, cnt;
    logic [15:0] y;
    bit          ok;
    bit          all_lat;
    logic [15:0] y1, y32, y64;

    initial begin
        reset = 1'b1; sample_strb = 1'b0; new_sample = '0; preload = 1'b0; preload_val = '0;
        set_coefs(16'h0000, 16'h0000);
        do_preload(16'h0000);
        repeat (2) @(negedge clk);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_flags", {y_valid, busy, overrun}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Unity tap, with address sweep / busy window checked along the way
        set_coefs(16'h7FFF, 16'h0000);
        sweep(16'd100, 0, vc, y, ov, ok);
        chk("unity_lat", vc, LAT);
        chk("unity_y", y, 16'd100);
        chk("unity_seq", ok, 1);
        chk("unity_no_ovr", ov, -1);
        @(negedge clk);
        chk("idle_addr", {read_addr, busy}, 0);

        sweep(16'hFF9C, 0, vc, y, ov, ok);
        chk("neg_round_y", y, 16'hFF9C);
        @(negedge clk);

        // Half-LSB cases: +0.5 rounds up, -0.5 rounds to zero
        set_coefs(16'h4000, 16'h0000);
        sweep(16'h0001, 0, vc, y, ov, ok);
        chk("half_pos_y", y, 16'h0001);
        @(negedge clk);
        sweep(16'hFFFF, 0, vc, y, ov, ok);
        chk("half_neg_y", y, 16'h0000);
        @(negedge clk);

        set_coefs(16'h8000, 16'h0000);
        sweep(16'h8000, 0, vc, y, ov, ok);
        chk("minmin_sat", y, 16'h7FFF);
        @(negedge clk);

        // Averaging: back-to-back strobes at the minimum spacing
        set_coefs(16'h4000, 16'h4000);
        do_preload(16'h0000);
        all_lat = 1'b1; y1 = '0; y32 = '0; y64 = '0;
        for (int k = 1; k <= TAPS; k++) begin
            sweep(16'd1000, 0, vc, y, ov, ok);
            if (vc != LAT || !ok || ov != -1) all_lat = 1'b0;
            if (k == 1)  y1 = y;
            if (k == 32) y32 = y;
            if (k == 64) y64 = y;
        end
        chk("avg_spacing", all_lat, 1);
        chk("avg_y1", y1, 16'd500);
        chk("avg_y32", y32, 16'd16000);
        chk("avg_y64", y64, 16'd32000);
        @(negedge clk);

        set_coefs(16'h7FFF, 16'h7FFF);
        do_preload(16'h7FFF);
        sweep(16'h7FFF, 0, vc, y, ov, ok);
        chk("sat_pos", y, 16'h7FFF);
        @(negedge clk);
        do_preload(16'h8000);
        sweep(16'h8000, 0, vc, y, ov, ok);
        chk("sat_neg", y, 16'h8000);
        @(negedge clk);

        // Overrun: second strobe in cycle 10
        set_coefs(16'h7FFF, 16'h0000);
        sweep(16'd100, 10, vc, y, ov, ok);
        chk("ovr_cycle", ov, 11);
        chk("ovr_lat", vc, LAT);
        chk("ovr_seq", ok, 1);
        count_valids(80, cnt);
        chk("ovr_one_valid", cnt, 0);

        // Reset mid-sweep at read_addr 30
        new_sample  = 16'd7;
        sample_strb = 1'b1;
        @(negedge clk);
        sample_strb = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (read_addr == 6'd30) ok = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_reach30", ok, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_addr", read_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_y", y_out, 0);
        chk("midrst_valid", y_valid, 0);
        count_valids(80, cnt);
        chk("midrst_no_valid", cnt, 0);
        sweep(16'd100, 0, vc, y, ov, ok);
        chk("postrst_lat", vc, LAT);
        chk("postrst_y", y, 16'd100);
        chk("postrst_seq", ok, 1);
        @(negedge clk);

        // Reset and strobe together: no sweep starts
        reset = 1'b1; sample_strb = 1'b1;
        @(negedge clk);
        reset = 1'b0; sample_strb = 1'b0;
        chk("rststrb_busy0", busy, 0);
        @(negedge clk);
        chk("rststrb_busy1", {busy, read_addr}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
